stream_mux_arb: RTL and testbench
=================================

# stream_mux_arb

Parametrised N-channel registered stream multiplexer with valid/ready handshake on every input and on the output. It generalises the two-level select-tree mux into a pipelined selector with three modes: manual select (external index, like a wide mux), fixed priority, and round-robin arbitration. It sits between multiple producers and a single shared consumer. It provides one register stage, full throughput, and backpressure propagation.

## Interface
- `N`, default 4: number of input channels; legal range 2..16.
- `WIDTH`, default 8: data width per channel.
- `MODE`, default 1: 0 = manual select, 1 = round-robin, 2 = fixed priority (lowest index wins).
- `SEL_W`, default `$clog2(N)`: width of select/index fields; derived, not overridden.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, N: per-channel valid; bit i belongs to channel i.
- `in_data`, input, N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_ready`, output, N: per-channel ready; at most one bit set in any cycle.
- `sel`, input, SEL_W: channel index used in MODE 0; ignored in other modes.
- `out_valid`, output, 1: output register holds a beat.
- `out_data`, output, WIDTH: registered data.
- `out_sel`, output, SEL_W: index of the channel that supplied `out_data`.
- `out_ready`, input, 1: consumer accepts a beat when high together with `out_valid`.

## Operation
- `load = out_ready | ~out_valid`, meaning the output register is empty or draining this cycle.
- Grant `g` is computed combinationally from `in_valid` and the mode:
  - MODE 0: `g = sel`. The grant is active only if `in_valid[sel]`. A `sel >= N` gives no grant.
  - MODE 1: first set `in_valid` bit searching upward from `rr_ptr`, wrapping at N-1 to 0.
  - MODE 2: lowest-index set `in_valid` bit.
- `in_ready[g] = load & grant_active`. All other `in_ready` bits are 0.
- Accept: `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data <= in_data[g]`.
  - `out_sel <= g`.
  - `out_valid <= 1`.
- If `load` is high and there is no accept: `out_valid <= 0`. `out_data` and `out_sel` hold.
- If `load` is low: the output register holds, and `out_data` must be stable while `out_valid & ~out_ready`.
- `rr_ptr` (SEL_W bits, MODE 1 only) updates on an accept to `g+1`, wrapping N-1 to 0. Without an accept it holds.
- In MODE 0 and MODE 2, `rr_ptr` stays 0.
- Simultaneous accept and output drain in the same cycle is legal. The output register is replaced with no bubble.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. No input depends combinationally on `in_ready`.
- Changing `sel` mid-stream in MODE 0 takes effect on the next cycle's grant. A beat already in the output register is unaffected.

## Timing
- Reset (asserted asynchronously, released synchronously to `clk` by the system) sets: `out_valid=0`, `out_data=0`, `out_sel=0`, `rr_ptr=0`.
- `in_ready` is 0 during reset.
- Reset mid-transfer drops the held beat. No partial state survives.
- Latency: a beat accepted at edge k appears on `out_valid/out_data` after edge k, one cycle.
- Throughput: one beat per cycle when `out_ready` is held high and any channel is valid.
- Fairness (MODE 1): with all N channels continuously valid and `out_ready=1`, grants follow 0,1,…,N-1,0,… with no channel starved more than N-1 cycles.
- Backpressure: with `out_ready=0` and `out_valid=1`, all `in_ready` bits are 0 and all state holds.

## Test plan
- Reset then idle: `rst_n=0` for 3 cycles, then release with `in_valid=0`. Required: `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0` throughout.
- MODE 1, N=4, WIDTH=8: channels i=0..3 present data `0x10+i`, all valid, `out_ready=1` for 8 cycles. Required: `out_sel` sequence 0,1,2,3,0,1,2,3 and `out_data` 0x10,0x11,0x12,0x13,…, one beat per cycle.
- MODE 2: `in_valid=4'b1010`, data ch1=0xA1, ch3=0xA3. Required: ch1 wins every cycle, `in_ready=4'b0010`, `out_data=0xA1`, and ch3 is never granted while ch1 stays valid.
- MODE 0: `sel=2`, `in_valid=4'b1111`, ch2 data=0x5C. Required: only `in_ready[2]=1` and `out_sel=2`, `out_data=0x5C`. Then `sel=2` with `in_valid[2]=0` gives `in_ready=0` and `out_valid` falls the next cycle.
- Backpressure: a beat 0x33 is held with `out_ready=0` for 5 cycles while other channels are valid. Required: `out_data=0x33` stable, `in_ready=0`, `rr_ptr` unchanged. After `out_ready=1` the next beat follows with no bubble.
- Async reset mid-stream: assert `rst_n=0` between clock edges while `out_valid=1`. Required: `out_valid` drops to 0 immediately, without waiting for a clock edge. After release, the first MODE 1 grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb
// Purpose  : N-channel registered stream multiplexer with valid/ready on every
//            input and on the output. The channel is picked by an external
//            index (MODE 0), by round-robin arbitration (MODE 1) or by fixed
//            priority with the lowest index winning (MODE 2). One output
//            register stage, full throughput, backpressure passes through.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid[N]           - per-channel valid
//            in_data[N*WIDTH]      - channel i at [i*WIDTH +: WIDTH]
//            in_ready[N]           - per-channel ready, at most one bit high
//            sel[SEL_W]            - channel index, used in MODE 0 only
//            out_valid/out_data    - registered output beat
//            out_sel[SEL_W]        - channel that supplied out_data
//            out_ready             - consumer accepts when high with out_valid
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  localparam int c_last_idx = N - 1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;

  logic             w_load;
  logic             w_take;
  logic             w_grant_act;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_grant_data;

  // base + off, wrapping past the last channel back to 0 (off < N)
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s > c_last_idx) s = s - N;
    return SEL_W'(s);
  endfunction

  // The output register can take a new beat when empty or draining now
  assign w_load = out_ready | ~r_out_valid;
  // A granted channel is always valid, so grant & load is the accept
  assign w_take = w_grant_act & w_load;

  generate
    if (MODE == 0) begin : g_manual
      // Comparing against every legal index makes sel >= N grant nothing
      always_comb begin
        w_grant_idx = sel;
        w_grant_act = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (sel == SEL_W'(i)) w_grant_act = in_valid[i];
        end
      end
    end else if (MODE == 1) begin : g_round_robin
      logic [SEL_W-1:0] r_rr_ptr;
      logic             w_sel_unused;

      assign w_sel_unused = ^sel;

      // Scan from farthest to nearest so the nearest valid channel at or
      // after the pointer is the last (winning) assignment
      always_comb begin
        w_grant_idx = '0;
        w_grant_act = 1'b0;
        for (int k = c_last_idx; k >= 0; k--) begin
          if (in_valid[wrap_add(r_rr_ptr, k)]) begin
            w_grant_idx = wrap_add(r_rr_ptr, k);
            w_grant_act = 1'b1;
          end
        end
      end

      // Pointer moves just past the channel that was served
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rr_ptr <= '0;
        end else if (w_take) begin
          r_rr_ptr <= wrap_add(w_grant_idx, 1);
        end
      end
    end else begin : g_priority
      logic w_sel_unused;

      assign w_sel_unused = ^sel;

      // Downward scan: the lowest valid index is assigned last and wins
      always_comb begin
        w_grant_idx = '0;
        w_grant_act = 1'b0;
        for (int i = c_last_idx; i >= 0; i--) begin
          if (in_valid[i]) begin
            w_grant_idx = SEL_W'(i);
            w_grant_act = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_idx == SEL_W'(i)) w_grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gating keeps every ready low while the block is held in reset
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && w_take && (w_grant_idx == SEL_W'(i))) in_ready[i] = 1'b1;
    end
  end

  // Output register: replace on accept, empty on load without accept,
  // otherwise hold (stalled beat stays stable)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_sel   <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_arb
// Purpose  : Self-checking bench. Three instances (MODE 0, 1, 2) share one
//            stimulus; a behavioural model per mode predicts in_ready and the
//            output register every cycle. Directed steps are followed by a
//            randomized segment.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_arb;

  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic             out_ready;

  logic [N-1:0]     rdy [3];
  logic             ov  [3];
  logic [WIDTH-1:0] od  [3];
  logic [1:0]       os  [3];

  int errors = 0;
  int checks = 0;

  // model state, indexed by mode number
  logic       mv [3];
  logic [7:0] md [3];
  logic [1:0] ms [3];
  int         mp [3];

  stream_mux_arb #(.N(N), .WIDTH(WIDTH), .MODE(0)) u_man (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .sel(sel), .out_valid(ov[0]), .out_data(od[0]),
    .out_sel(os[0]), .out_ready(out_ready));

  stream_mux_arb #(.N(N), .WIDTH(WIDTH), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .sel(sel), .out_valid(ov[1]), .out_data(od[1]),
    .out_sel(os[1]), .out_ready(out_ready));

  stream_mux_arb #(.N(N), .WIDTH(WIDTH), .MODE(2)) u_pri (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .sel(sel), .out_valid(ov[2]), .out_data(od[2]),
    .out_sel(os[2]), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 2'd0; mp[m] = 0;
    end
  endtask

  // Which channel the rules pick for a mode, from current inputs
  task automatic grant(input int m, output bit act, output int g);
    act = 1'b0;
    g   = 0;
    if (m == 0) begin
      g   = int'(sel);
      act = in_valid[sel];
    end else if (m == 1) begin
      for (int k = 0; k < N; k++)
        if (!act && in_valid[(mp[1] + k) % N]) begin act = 1'b1; g = (mp[1] + k) % N; end
    end else begin
      for (int k = 0; k < N; k++)
        if (!act && in_valid[k]) begin act = 1'b1; g = k; end
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs
  task automatic tick();
    bit act [3];
    int g   [3];
    bit ld  [3];
    logic [N-1:0] er;
    #1;
    for (int m = 0; m < 3; m++) begin
      grant(m, act[m], g[m]);
      ld[m] = out_ready || !mv[m];
      er = (rst_n && act[m] && ld[m]) ? N'(1 << g[m]) : '0;
      check($sformatf("in_ready_m%0d", m), 32'(rdy[m]), 32'(er));
    end
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      if (!rst_n) begin
        mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 2'd0; mp[m] = 0;
      end else if (ld[m]) begin
        if (act[m]) begin
          mv[m] = 1'b1;
          md[m] = in_data[g[m]*WIDTH +: WIDTH];
          ms[m] = 2'(g[m]);
          if (m == 1) mp[m] = (g[m] + 1) % N;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
    #1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("out_valid_m%0d", m), 32'(ov[m]), 32'(mv[m]));
      check($sformatf("out_data_m%0d", m),  32'(od[m]), 32'(md[m]));
      check($sformatf("out_sel_m%0d", m),   32'(os[m]), 32'(ms[m]));
    end
    @(negedge clk);
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = base + 8'(i);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; sel = 2'd0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // reset held 3 cycles, idle inputs; one cycle with valids to see gating
    tick();
    in_valid = 4'hF; set_data(8'h77);
    tick();
    in_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // round-robin sweep: all valid, consumer always ready
    set_data(8'h10); in_valid = 4'hF; out_ready = 1'b1; sel = 2'd1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_seq_sel", 32'(os[1]), 32'(k % N));
      check("rr_seq_data", 32'(od[1]), 32'(8'h10 + 8'(k % N)));
    end

    // fixed priority: ch1 must beat ch3 every cycle
    in_valid = 4'b1010;
    in_data[1*WIDTH +: WIDTH] = 8'hA1;
    in_data[3*WIDTH +: WIDTH] = 8'hA3;
    for (int k = 0; k < 4; k++) begin
      #1 check("pri_ready", 32'(rdy[2]), 32'h2);
      tick();
      check("pri_data", 32'(od[2]), 32'hA1);
      check("pri_sel", 32'(os[2]), 32'h1);
    end

    // manual select ch2, then ch2 goes idle
    in_valid = 4'hF; sel = 2'd2; set_data(8'h50);
    in_data[2*WIDTH +: WIDTH] = 8'h5C;
    #1 check("man_ready", 32'(rdy[0]), 32'h4);
    tick();
    check("man_sel", 32'(os[0]), 32'h2);
    check("man_data", 32'(od[0]), 32'h5C);
    in_valid = 4'b1011;
    #1 check("man_ready_idle", 32'(rdy[0]), 32'h0);
    tick();
    check("man_valid_fall", 32'(ov[0]), 32'h0);

    // backpressure: drain, load 0x33 from ch0, stall 5 cycles, resume
    in_valid = 4'h0; tick();
    in_valid = 4'h1; in_data[7:0] = 8'h33; tick();
    check("bp_load", 32'(od[1]), 32'h33);
    out_ready = 1'b0; in_valid = 4'hF; set_data(8'h40);
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_ready", 32'(rdy[1]), 32'h0);
      tick();
      check("bp_hold", 32'(od[1]), 32'h33);
      check("bp_valid", 32'(ov[1]), 32'h1);
    end
    out_ready = 1'b1;
    #1 check("bp_resume_ready", 32'(rdy[1]), 32'h2);
    tick();
    check("bp_next_sel", 32'(os[1]), 32'h1);
    check("bp_next_data", 32'(od[1]), 32'h41);
    tick();

    // asynchronous reset between edges while a beat is held
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) begin
      check($sformatf("async_valid_m%0d", m), 32'(ov[m]), 32'h0);
      check($sformatf("async_ready_m%0d", m), 32'(rdy[m]), 32'h0);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1; in_valid = 4'hF; set_data(8'h60); out_ready = 1'b1;
    tick();
    check("post_reset_rr_sel", 32'(os[1]), 32'h0);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 32'($urandom);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
